// File: rtl/bin_to_ascii_stream.sv
// Converts a DATA_W-bit word into a hex ASCII character stream, MSB nibble first, with optional CR/LF.
// Latency: first character 1 cycle after accept, then one character per out handshake; in_ready only in IDLE.
// Backpressure: out_char/state hold while out_valid && !out_ready; in_ready stays low until the word is fully emitted.
module bin_to_ascii_stream #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              lower,
    input  logic              suppress_zeros,
    input  logic              add_crlf,
    output logic [7:0]        out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    localparam int NDIG = DATA_W / 4;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, DIGITS, CR, LF} state_t;

    state_t            state;
    logic [DATA_W-1:0] word_q;
    logic              lower_q;
    logic              crlf_q;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     start_idx;

    function automatic logic [7:0] to_ascii(input logic [3:0] nib, input logic lc);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return (lc ? 8'h57 : 8'h37) + {4'h0, nib};
    endfunction

    function automatic logic [3:0] digit_at(input logic [DATA_W-1:0] w, input logic [IW-1:0] i);
        logic [DATA_W-1:0] sh;
        sh = w >> {i, 2'b00};
        return sh[3:0];
    endfunction

    // Highest nonzero nibble; an all-zero word still yields one '0' digit at index 0.
    function automatic logic [IW-1:0] msd(input logic [DATA_W-1:0] w);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++)
            if (w[i*4 +: 4] != 4'h0)
                r = IW'(i);
        return r;
    endfunction

    always_comb begin
        start_idx = IW'(NDIG - 1);
        if (suppress_zeros)
            start_idx = msd(in_data);
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            busy      <= 1'b0;
            idx       <= '0;
            word_q    <= '0;
            lower_q   <= 1'b0;
            crlf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_q    <= in_data;
                        lower_q   <= lower;
                        crlf_q    <= add_crlf;
                        idx       <= start_idx;
                        out_char  <= to_ascii(digit_at(in_data, start_idx), lower);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= DIGITS;
                    end
                end
                DIGITS: begin
                    if (out_ready) begin
                        if (idx != '0) begin
                            idx      <= idx - 1'b1;
                            out_char <= to_ascii(digit_at(word_q, idx - 1'b1), lower_q);
                        end else if (crlf_q) begin
                            out_char <= 8'h0D;
                            state    <= CR;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                CR: begin
                    if (out_ready) begin
                        out_char <= 8'h0A;
                        state    <= LF;
                    end
                end
                LF: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_ascii_stream.sv
// Directed bench for bin_to_ascii_stream at DATA_W = 16, 8 and 32.
module tb_bin_to_ascii_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // 16-bit instance
    logic        rst16 = 1'b1, in_valid16 = 1'b0, lower16 = 1'b0, sz16 = 1'b0, crlf16 = 1'b0, out_ready16 = 1'b1;
    logic [15:0] in_data16 = '0;
    logic        in_ready16, out_valid16, busy16;
    logic [7:0]  out_char16;
    // 8-bit instance
    logic        rst8 = 1'b1, in_valid8 = 1'b0, lower8 = 1'b0, sz8 = 1'b0, crlf8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  in_data8 = '0;
    logic        in_ready8, out_valid8, busy8;
    logic [7:0]  out_char8;
    // 32-bit instance
    logic        rst32 = 1'b1, in_valid32 = 1'b0, lower32 = 1'b0, sz32 = 1'b0, crlf32 = 1'b0, out_ready32 = 1'b1;
    logic [31:0] in_data32 = '0;
    logic        in_ready32, out_valid32, busy32;
    logic [7:0]  out_char32;

    bin_to_ascii_stream #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst16), .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
        .lower(lower16), .suppress_zeros(sz16), .add_crlf(crlf16),
        .out_char(out_char16), .out_valid(out_valid16), .out_ready(out_ready16), .busy(busy16));
    bin_to_ascii_stream #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst8), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .lower(lower8), .suppress_zeros(sz8), .add_crlf(crlf8),
        .out_char(out_char8), .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8));
    bin_to_ascii_stream #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst32), .in_data(in_data32), .in_valid(in_valid32), .in_ready(in_ready32),
        .lower(lower32), .suppress_zeros(sz32), .add_crlf(crlf32),
        .out_char(out_char32), .out_valid(out_valid32), .out_ready(out_ready32), .busy(busy32));

    // Inputs only change at posedge+1, so the negedge view is exactly what the next edge will see.
    logic [7:0] q16[$], q8[$], q32[$];
    always @(negedge clk) begin
        if (!rst16 && out_valid16 && out_ready16) q16.push_back(out_char16);
        if (!rst8  && out_valid8  && out_ready8)  q8.push_back(out_char8);
        if (!rst32 && out_valid32 && out_ready32) q32.push_back(out_char32);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkq(input string tag, input logic [7:0] q[$], input string e);
        chk({tag, "_len"}, 64'(q.size()), 64'(e.len()));
        for (int i = 0; i < e.len() && i < q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), {56'h0, q[i]}, {56'h0, e[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [15:0] d, input logic lo, input logic sz, input logic cr);
        int n = 0;
        while (!in_ready16 && n < 200) begin tick(); n++; end
        chk("send16_ready", {63'h0, in_ready16}, 64'h1);
        in_data16 = d; lower16 = lo; sz16 = sz; crlf16 = cr; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
    endtask

    task automatic drain16(input string tag);
        int n = 0;
        while ((out_valid16 || busy16) && n < 200) begin tick(); n++; end
        chk({tag, "_drain"}, {63'h0, (n < 200)}, 64'h1);
    endtask

    task automatic send8(input logic [7:0] d, input logic lo, input logic sz, input logic cr);
        chk("send8_ready", {63'h0, in_ready8}, 64'h1);
        in_data8 = d; lower8 = lo; sz8 = sz; crlf8 = cr; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        repeat (20) tick();
    endtask

    task automatic send32(input logic [31:0] d, input logic lo, input logic sz, input logic cr);
        chk("send32_ready", {63'h0, in_ready32}, 64'h1);
        in_data32 = d; lower32 = lo; sz32 = sz; crlf32 = cr; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        repeat (2) tick();
        rst16 = 1'b0; rst8 = 1'b0; rst32 = 1'b0;
        @(negedge clk);
        chk("rst_valid", {63'h0, out_valid16}, 64'h0);
        chk("rst_char",  {56'h0, out_char16}, 64'h00);
        chk("rst_busy",  {63'h0, busy16}, 64'h0);
        chk("rst_ready", {63'h0, in_ready16}, 64'h1);

        // Cycle-exact: 1A3F uppercase, no suppression
        tick();
        q16.delete();
        in_data16 = 16'h1A3F; lower16 = 1'b0; sz16 = 1'b0; crlf16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        @(negedge clk); chk("t1_c0", {56'h0, out_char16}, 64'h31); chk("t1_v0", {63'h0, out_valid16}, 64'h1);
        @(negedge clk); chk("t1_c1", {56'h0, out_char16}, 64'h41);
        @(negedge clk); chk("t1_c2", {56'h0, out_char16}, 64'h33);
        @(negedge clk); chk("t1_c3", {56'h0, out_char16}, 64'h46);
        @(negedge clk); chk("t1_ready", {63'h0, in_ready16}, 64'h1); chk("t1_vend", {63'h0, out_valid16}, 64'h0);
        chkq("t1_seq", q16, "1A3F");

        // Suppression and lowercase
        tick(); q16.delete();
        send16(16'h00B0, 1'b1, 1'b1, 1'b0); drain16("t2a");
        chkq("t2a_seq", q16, "b0");
        q16.delete();
        send16(16'h0000, 1'b0, 1'b1, 1'b0); drain16("t2b");
        chkq("t2b_seq", q16, "0");

        // CR/LF terminator
        q16.delete();
        send16(16'h0007, 1'b0, 1'b0, 1'b1); drain16("t3");
        chkq("t3_seq", q16, "0007\r\n");
        @(negedge clk);
        chk("t3_valid", {63'h0, out_valid16}, 64'h0);
        chk("t3_busy",  {63'h0, busy16}, 64'h0);

        // Backpressure on second character, with input changes mid-stream
        tick(); q16.delete();
        send16(16'hC0DE, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready16 = 1'b0; in_data16 = 16'hFFFF; lower16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold_c%0d", i), {56'h0, out_char16}, 64'h30);
            chk($sformatf("t4_hold_v%0d", i), {63'h0, out_valid16}, 64'h1);
            tick();
        end
        out_ready16 = 1'b1;
        @(negedge clk); chk("t4_rel0", {56'h0, out_char16}, 64'h30);
        @(negedge clk); chk("t4_rel1", {56'h0, out_char16}, 64'h44);
        @(negedge clk); chk("t4_rel2", {56'h0, out_char16}, 64'h45);
        drain16("t4");
        chkq("t4_seq", q16, "C0DE");

        // Back-to-back words with in_valid held high
        tick(); q16.delete();
        in_data16 = 16'h0012; lower16 = 1'b0; sz16 = 1'b1; crlf16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_data16 = 16'h0034;
        @(negedge clk); chk("t5_busy", {63'h0, busy16}, 64'h1);
        tick(); tick();
        @(negedge clk);
        chk("t5_turn_ready", {63'h0, in_ready16}, 64'h1);
        chk("t5_turn_valid", {63'h0, out_valid16}, 64'h0);
        tick();
        in_valid16 = 1'b0;
        @(negedge clk);
        chk("t5_second_c", {56'h0, out_char16}, 64'h33);
        chk("t5_second_rdy", {63'h0, in_ready16}, 64'h0);
        drain16("t5");
        chkq("t5_seq", q16, "1234");

        // Reset during the third digit
        tick(); q16.delete(); sz16 = 1'b0;
        send16(16'h1234, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst16 = 1'b1;
        @(negedge clk); chk("t6_pre_c", {56'h0, out_char16}, 64'h33);
        tick();
        rst16 = 1'b0;
        @(negedge clk);
        chk("t6_valid", {63'h0, out_valid16}, 64'h0);
        chk("t6_char",  {56'h0, out_char16}, 64'h00);
        chk("t6_busy",  {63'h0, busy16}, 64'h0);
        chk("t6_ready", {63'h0, in_ready16}, 64'h1);
        chkq("t6_partial", q16, "12");
        tick(); q16.delete();
        send16(16'hFFFF, 1'b0, 1'b0, 1'b0); drain16("t6");
        chkq("t6_seq", q16, "FFFF");

        // DATA_W = 8
        q8.delete();
        send8(8'hA5, 1'b0, 1'b0, 1'b0);
        chkq("w8_a", q8, "A5");
        q8.delete();
        send8(8'h00, 1'b0, 1'b1, 1'b1);
        chkq("w8_b", q8, "0\r\n");
        q8.delete();
        in_data8 = 8'hFE; lower8 = 1'b0; sz8 = 1'b0; crlf8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0; rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        @(negedge clk);
        chk("w8_rst_valid", {63'h0, out_valid8}, 64'h0);
        chk("w8_rst_ready", {63'h0, in_ready8}, 64'h1);
        tick();
        send8(8'h3c, 1'b1, 1'b0, 1'b0);
        chkq("w8_c", q8, "3c");

        // DATA_W = 32
        q32.delete();
        send32(32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        chkq("w32_a", q32, "deadbeef\r\n");
        q32.delete();
        send32(32'h0000_1000, 1'b0, 1'b1, 1'b0);
        chkq("w32_b", q32, "1000");
        q32.delete();
        send32(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        chkq("w32_c", q32, "00000000");
        chk("w32_idle", {63'h0, busy32}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bin_to_ascii_stream.md
Name: bin_to_ascii_stream

Overview:
- Parametrised successor to the 4-bit binary-to-ASCII converter.
- Accepts a DATA_W-bit binary word over a valid/ready handshake and emits its hexadecimal representation as a stream of 8-bit ASCII characters, MSB nibble first, one per accepted output beat.
- Adds run-time modes: lowercase hex, leading-zero suppression and optional CR/LF terminator.
- Sits between keypad/datapath producers and the UART/LCD character sinks.

Parameters:
- DATA_W, 16, input word width in bits. Must be a multiple of 4, range 4..64. NDIG = DATA_W/4 hex digits.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_W  binary word to convert.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- lower  input  1  1 = digits 10..15 as 'a'..'f' (97..102); 0 = 'A'..'F' (65..70). Sampled at accept.
- suppress_zeros  input  1  1 = skip leading zero digits. Sampled at accept.
- add_crlf  input  1  1 = append 13 then 10 after the last digit. Sampled at accept.
- out_char  output  8  ASCII character.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  sink accepts out_char.
- busy  output  1  a word is in progress (state != IDLE).

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - While rst=1 at a clock edge: state -> IDLE, out_valid=0, out_char=8'h00, busy=0, digit index cleared.
  - in_ready=1 in the first cycle after rst deasserts.
- States: IDLE, DIGITS, CR, LF.
- IDLE:
  - in_ready=1.
  - Accept occurs on in_valid && in_ready at a clock edge. At accept, latch in_data, lower, suppress_zeros and add_crlf.
  - Set the digit index:
    - suppress_zeros=0: index = NDIG-1.
    - suppress_zeros=1: index = position of the most significant nonzero nibble (priority encode). If the word is 0, index = 0.
  - Load out_char with the digit at that index, set out_valid=1, go to DIGITS.
  - Latency from accept edge to first out_valid: 1 cycle. There are no bubble cycles for skipped zeros.
- DIGITS:
  - in_ready=0.
  - On out_valid && out_ready:
    - index > 0: decrement the index and load the next digit. out_valid stays 1, giving back-to-back characters.
    - index = 0 and add_crlf=1: out_char=8'h0D, go to CR.
    - index = 0 and add_crlf=0: out_valid=0, go to IDLE.
- CR:
  - On handshake: out_char=8'h0A, go to LF.
- LF:
  - On handshake: out_valid=0, go to IDLE.
- Back-pressure: while out_valid=1 and out_ready=0, out_char and state are held stable.
- Turnaround: in_ready rises the cycle after the final character handshake, so there is one idle cycle between words. A word presented in that cycle is accepted immediately.
- Digit mapping: 0..9 -> 48..57. 10..15 -> 65..70 (lower=0) or 97..102 (lower=1). No other codes are produced by the digit path.
- Input changes after accept (in_data and mode pins) have no effect until the next accept.
- Reset mid-word: the in-flight word is discarded, no further characters are emitted, and out_valid drops on the reset edge.
- Output count per word: digits = NDIG, or (suppress_zeros=1) the number of significant digits with a minimum of 1; plus 2 if add_crlf=1.
- out_char, out_valid and busy are registered outputs. in_ready is decoded from state only.

Test Plan:
- DATA_W=16, in_data=16'h1A3F, lower=0, suppress=0, crlf=0, out_ready=1 -> 0x31, 0x41, 0x33, 0x46 on 4 consecutive cycles, starting 1 cycle after accept. in_ready=1 one cycle after the 0x46 handshake.
- in_data=16'h00B0, lower=1, suppress=1 -> exactly 0x62, 0x30. in_data=16'h0000, suppress=1 -> single 0x30.
- in_data=16'h0007, suppress=0, crlf=1 -> 0x30, 0x30, 0x30, 0x37, 0x0D, 0x0A, then out_valid=0 and busy=0.
- in_data=16'hC0DE, out_ready held low 3 cycles on the second character -> out_char stays 0x30 and the state is held. On release the sequence resumes 0x44, 0x45 with no loss or duplication. Changing in_data and lower during the stream has no effect.
- Two words presented back-to-back with in_valid held high -> the second is accepted exactly in the turnaround cycle, and the streams do not interleave.
- rst asserted for 1 cycle during the third digit of 16'h1234 -> out_valid=0 and out_char=0x00 after the edge, in_ready=1 the next cycle. A new word 16'hFFFF then yields 0x46 x4 cleanly. Repeat with DATA_W=8 and DATA_W=32 for boundary digit counts.
